// File: rtl/decoder_pkg.sv
// Shared types and constants for the 4-to-16 streaming one-hot decoder.
package decoder_pkg;

  localparam int unsigned DEC_WIDTH_IN  = 4;
  localparam int unsigned DEC_WIDTH_OUT = 16;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    DRAIN = 2'd1,
    SCAN  = 2'd2
  } dec_state_e;

  typedef logic [DEC_WIDTH_IN-1:0]  dec_idx_t;
  typedef logic [DEC_WIDTH_OUT-1:0] dec_onehot_t;

endpackage

// File: rtl/decoder416_stream_skid_buffer.sv
// Generic two-entry valid/ready buffer (output register plus one skid slot)
// with a registered ready that the owner can gate off via allow_i.
module skid_buffer #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              allow_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              skid_full_o
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              ready_q, ready_d;
  logic              accept, pop;

  assign accept = in_valid_i && ready_q;
  assign pop    = out_valid_q && out_ready_i;

  // ready_q tracks !skid_valid_q, so an accept never coincides with a full skid
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end
    ready_d = allow_i && !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign skid_full_o = skid_valid_q;

endmodule

// File: rtl/decoder416_stream.sv
// Registered 4-to-16 one-hot decoder with valid/ready on both sides and an
// autonomous scan mode that walks a single hot bit across the outputs.
module decoder416_stream
  import decoder_pkg::*;
#(
  parameter  int unsigned WIDTH_IN  = DEC_WIDTH_IN,
  parameter  int unsigned SCAN_LAST = 15,
  localparam int unsigned WIDTH_OUT = 2 ** WIDTH_IN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [WIDTH_IN-1:0]  dataIn,
  input  logic                 scanEn,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [WIDTH_OUT-1:0] dataOut,
  output logic                 scanActive
);

  if (SCAN_LAST >= WIDTH_OUT) begin : g_bad_scan_last
    $error("SCAN_LAST must be less than 2**WIDTH_IN");
  end

  dec_state_e          state_q, state_d;
  logic [WIDTH_IN-1:0] scan_idx_q, scan_idx_d;

  logic                sb_valid, sb_ready_in, sb_full;
  logic [WIDTH_IN-1:0] sb_data;
  logic                in_scan, out_xfer;
  logic [WIDTH_IN-1:0] out_idx;

  assign in_scan  = (state_q == SCAN);
  assign out_xfer = outValid && outReady;

  skid_buffer #(
    .DATA_W (WIDTH_IN)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .allow_i     (state_d == PASS),
    .in_valid_i  (inValid),
    .in_ready_o  (sb_ready_in),
    .in_data_i   (dataIn),
    .out_valid_o (sb_valid),
    .out_ready_i (outReady && !in_scan),
    .out_data_o  (sb_data),
    .skid_full_o (sb_full)
  );

  // Mode control: DRAIN empties the buffer before SCAN takes the output
  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    unique case (state_q)
      PASS: begin
        if (scanEn) state_d = DRAIN;
      end
      DRAIN: begin
        if (!sb_full && (!sb_valid || out_xfer)) begin
          if (scanEn) begin
            state_d    = SCAN;
            scan_idx_d = '0;
          end else begin
            state_d = PASS;
          end
        end
      end
      SCAN: begin
        if (out_xfer) begin
          scan_idx_d = (scan_idx_q == WIDTH_IN'(SCAN_LAST)) ? '0
                                                            : scan_idx_q + WIDTH_IN'(1);
          if (!scanEn) state_d = PASS;
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PASS;
      scan_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign out_idx    = in_scan ? scan_idx_q : sb_data;
  assign outValid   = in_scan || sb_valid;
  assign dataOut    = outValid ? (WIDTH_OUT'(1) << out_idx) : '0;
  assign inReady    = sb_ready_in;
  assign scanActive = in_scan;

endmodule

// File: tb/tb_decoder416_stream.sv
// Randomised and directed bench for decoder416_stream against a queue-based
// transaction model of the stream and its scan mode.
module tb_decoder416_stream;

  localparam int unsigned SCAN_LAST = 15;
  localparam int M_PASS  = 0;
  localparam int M_DRAIN = 1;
  localparam int M_SCAN  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [3:0]  dataIn = 4'h0;
  logic        scanEn = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] dataOut;
  logic        scanActive;

  int unsigned n_vec = 0;
  int unsigned n_miscompare = 0;

  int          m_mode;
  int          m_idx;
  bit          m_ready;
  bit          m_in_xfer;
  int          m_q[$];

  always #5 clk = ~clk;

  decoder416_stream #(
    .WIDTH_IN  (4),
    .SCAN_LAST (SCAN_LAST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inValid    (inValid),
    .inReady    (inReady),
    .dataIn     (dataIn),
    .scanEn     (scanEn),
    .outValid   (outValid),
    .outReady   (outReady),
    .dataOut    (dataOut),
    .scanActive (scanActive)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_valid();
    return (m_mode == M_SCAN) || (m_q.size() > 0);
  endfunction

  function automatic logic [31:0] exp_data();
    int i;
    if (!exp_valid()) return 32'h0;
    i = (m_mode == M_SCAN) ? m_idx : m_q[0];
    return 32'h1 << i;
  endfunction

  task automatic model_reset();
    m_mode    = M_PASS;
    m_idx     = 0;
    m_ready   = 1'b0;
    m_in_xfer = 1'b0;
    m_q.delete();
  endtask

  // Advance the model by one rising edge using the currently driven inputs
  task automatic model_edge();
    bit xo, xi, drained;
    int nm;
    xo      = exp_valid() && outReady;
    xi      = inValid && m_ready;
    drained = (m_q.size() == 0) || (m_q.size() == 1 && xo);
    nm      = m_mode;
    case (m_mode)
      M_PASS:  if (scanEn) nm = M_DRAIN;
      M_DRAIN: if (drained) begin
                 nm = scanEn ? M_SCAN : M_PASS;
                 if (scanEn) m_idx = 0;
               end
      default: if (xo) begin
                 m_idx = (m_idx + 1) % (SCAN_LAST + 1);
                 if (!scanEn) nm = M_PASS;
               end
    endcase
    if (m_mode != M_SCAN && xo) void'(m_q.pop_front());
    if (xi) m_q.push_back(int'(dataIn));
    m_mode    = nm;
    m_ready   = (m_mode == M_PASS) && (m_q.size() < 2);
    m_in_xfer = xi;
  endtask

  task automatic check_outputs();
    chk_eq("outValid",   32'(outValid),   32'(exp_valid()));
    chk_eq("dataOut",    32'(dataOut),    exp_data());
    chk_eq("inReady",    32'(inReady),    32'(m_ready));
    chk_eq("scanActive", 32'(scanActive), 32'(m_mode == M_SCAN));
  endtask

  task automatic cycle(input logic v, input logic [3:0] d, input logic r, input logic s);
    inValid  = v;
    dataIn   = d;
    outReady = r;
    scanEn   = s;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, then release
  task automatic do_reset();
    #3;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    scanEn   = 1'b0;
    #1;
    chk_eq("rst_outValid",   32'(outValid),   32'h0);
    chk_eq("rst_dataOut",    32'(dataOut),    32'h0);
    chk_eq("rst_inReady",    32'(inReady),    32'h0);
    chk_eq("rst_scanActive", 32'(scanActive), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk_eq("rel_inReady_low", 32'(inReady), 32'h0);
  endtask

  initial begin
    int bp[3];
    int k;
    bp[0] = 3; bp[1] = 7; bp[2] = 9;

    model_reset();
    do_reset();
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    chk_eq("rel_inReady_high", 32'(inReady), 32'h1);

    // Single decode
    cycle(1'b1, 4'hA, 1'b1, 1'b0);
    chk_eq("single_0400", 32'(dataOut), 32'h0400);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    chk_eq("single_idle", 32'(dataOut), 32'h0000);

    // Back-to-back streaming 0..15
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'(i), 1'b1, 1'b0);
      chk_eq("stream_beat", 32'(dataOut), 32'h1 << i);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Backpressure: outReady low for the first 4 cycles
    k = 0;
    for (int n = 0; n < 20 && k < 3; n++) begin
      cycle(1'b1, 4'(bp[k]), (n >= 4), 1'b0);
      if (m_in_xfer) k++;
      if (n == 1) chk_eq("bp_ready_low", 32'(inReady), 32'h0);
    end
    chk_eq("bp_all_sent", 32'(k), 32'd3);
    repeat (4) cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Scan after a pending beat, run past the wrap
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    for (int n = 0; n < 22; n++) cycle(1'b1, 4'(n), 1'b1, 1'b1);
    // Drop scanEn while stalled: the current beat is held, then PASS
    repeat (3) cycle(1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Reset in the middle of a scan at index 5
    for (int n = 0; n < 40 && !(m_mode == M_SCAN && m_idx == 5); n++)
      cycle(1'b0, 4'h0, 1'b1, 1'b1);
    chk_eq("scan_at5", 32'(dataOut), 32'h0020);
    do_reset();
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    chk_eq("rescan_start", 32'(dataOut), 32'h0001);
    repeat (3) cycle(1'b0, 4'h0, 1'b1, 1'b1);

    // Random traffic with occasional scan requests
    scanEn = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic s;
      s = scanEn;
      if ($urandom_range(0, 39) == 0) s = ~s;
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7), s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
